// File: rtl/eh2_iccm_port_arb.sv
// ICCM port arbiter: schedules correction write-back, IFU fetch and DMA onto one ICCM port.
// Latency: grant is combinational in cycle N. Strobes are registered at N+1. Read response arrives at N+1+RD_LAT.
// Backpressure: losers are simply not granted. Responses cannot be stalled.
//
// Ports:
//   clk, rst                         core clock, asynchronous active-high reset
//   corr_*                           ECC correction write-back request/grant
//   fetch_*                          IFU fetch read request/grant, thread id, flush
//   dma_*                            DMA read/write request/grant
//   iccm_wren/rden/rw_addr/wr_*      registered ICCM control strobes
//   iccm_rd_data                     raw ICCM read data
//   fetch_rsp_*, dma_rsp_valid       read-response routing to the owner
//   rsp_data                         read data pass-through
//   busy                             strobe active or any read in flight
module eh2_iccm_port_arb #(
  parameter int ICCM_BITS      = 16,
  parameter int RD_LAT         = 2,
  parameter int DMA_STARVE_MAX = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   corr_req,
  input  logic [ICCM_BITS-1:1]   corr_addr,
  input  logic [77:0]            corr_data,
  output logic                   corr_gnt,
  input  logic                   fetch_req,
  input  logic                   fetch_tid,
  input  logic [ICCM_BITS-1:1]   fetch_addr,
  input  logic                   fetch_flush,
  output logic                   fetch_gnt,
  input  logic                   dma_req,
  input  logic                   dma_write,
  input  logic [2:0]             dma_size,
  input  logic [ICCM_BITS-1:1]   dma_addr,
  input  logic [77:0]            dma_wdata,
  output logic                   dma_gnt,
  output logic                   iccm_wren,
  output logic                   iccm_rden,
  output logic [ICCM_BITS-1:1]   iccm_rw_addr,
  output logic [2:0]             iccm_wr_size,
  output logic [77:0]            iccm_wr_data,
  input  logic [63:0]            iccm_rd_data,
  output logic                   fetch_rsp_valid,
  output logic                   fetch_rsp_tid,
  output logic                   dma_rsp_valid,
  output logic [63:0]            rsp_data,
  output logic                   busy
);

  localparam logic [3:0] STARVE_MAX = 4'(DMA_STARVE_MAX);

  // Tag carried alongside each read so the response can be routed to its owner.
  typedef struct packed {
    logic vld;
    logic is_dma;
    logic tid;
  } rd_tag_t;

  logic [3:0]           starve_q, starve_d;
  logic                 wren_q, wren_d;
  logic                 rden_q, rden_d;
  logic [ICCM_BITS-1:1] addr_q, addr_d;
  logic [2:0]           size_q, size_d;
  logic [77:0]          data_q, data_d;
  rd_tag_t              trk_q, trk_d;
  rd_tag_t              pipe_q [RD_LAT];
  rd_tag_t              pipe_d [RD_LAT];
  logic                 dma_starved;
  logic                 any_vld;

  // A flush only kills fetch-owned reads; DMA reads always complete.
  function automatic rd_tag_t flush_filter(input rd_tag_t t, input logic flush);
    rd_tag_t r;
    r = t;
    if (flush && !t.is_dma) r.vld = 1'b0;
    return r;
  endfunction

  // Grant: correction first, then a starved DMA, then fetch, then DMA.
  always_comb begin
    dma_starved = dma_req && (starve_q == STARVE_MAX);
    corr_gnt    = corr_req;
    dma_gnt     = !corr_req && dma_req && (dma_starved || !fetch_req);
    fetch_gnt   = !corr_req && fetch_req && !dma_starved;
  end

  // Starve counter: counts consecutive denied DMA cycles, saturating. A
  // correction can still win over a starved DMA, in which case it holds at max.
  always_comb begin
    starve_d = starve_q;
    if (!dma_req || dma_gnt) begin
      starve_d = 4'd0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Next registered strobes. Address, size and data hold when nothing is granted.
  always_comb begin
    wren_d = corr_gnt | (dma_gnt & dma_write);
    rden_d = fetch_gnt | (dma_gnt & !dma_write);
    addr_d = addr_q;
    size_d = size_q;
    data_d = data_q;
    if (corr_gnt) begin
      addr_d = corr_addr;
      size_d = 3'b011;
      data_d = corr_data;
    end else if (dma_gnt) begin
      addr_d = dma_addr;
      size_d = dma_write ? dma_size  : 3'b000;
      data_d = dma_write ? dma_wdata : 78'd0;
    end else if (fetch_gnt) begin
      addr_d = fetch_addr;
      size_d = 3'b000;
      data_d = 78'd0;
    end
  end

  // Read tracking. trk holds the tag for the read being strobed this cycle.
  // pipe[0..RD_LAT-1] follows it, so the last stage lines up with read data.
  // The iccm_rden strobe itself is not cancelled by a flush; only the tag is.
  always_comb begin
    trk_d.vld    = rden_d && !(fetch_gnt && fetch_flush);
    trk_d.is_dma = dma_gnt;
    trk_d.tid    = fetch_gnt ? fetch_tid : 1'b0;
    pipe_d[0]    = flush_filter(trk_q, fetch_flush);
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = flush_filter(pipe_q[i-1], fetch_flush);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= 4'd0;
      wren_q   <= 1'b0;
      rden_q   <= 1'b0;
      addr_q   <= '0;
      size_q   <= 3'b000;
      data_q   <= 78'd0;
      trk_q    <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      starve_q <= starve_d;
      wren_q   <= wren_d;
      rden_q   <= rden_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      data_q   <= data_d;
      trk_q    <= trk_d;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  always_comb begin
    any_vld = trk_q.vld;
    for (int i = 0; i < RD_LAT; i++) begin
      any_vld = any_vld | pipe_q[i].vld;
    end
  end

  assign iccm_wren       = wren_q;
  assign iccm_rden       = rden_q;
  assign iccm_rw_addr    = addr_q;
  assign iccm_wr_size    = size_q;
  assign iccm_wr_data    = data_q;
  assign fetch_rsp_valid = pipe_q[RD_LAT-1].vld & ~pipe_q[RD_LAT-1].is_dma;
  assign fetch_rsp_tid   = pipe_q[RD_LAT-1].tid;
  assign dma_rsp_valid   = pipe_q[RD_LAT-1].vld & pipe_q[RD_LAT-1].is_dma;
  assign rsp_data        = iccm_rd_data;
  assign busy            = wren_q | rden_q | any_vld;

endmodule

// File: doc/eh2_iccm_port_arb.md
Name: eh2_iccm_port_arb

Overview:
- Single-port ICCM access scheduler between the ECC correction write-back path, the IFU fetch (two threads) and the DMA slave.
- Grants one requester per cycle and drives the registered ICCM control strobes.
- Tracks in-flight reads through a latency pipeline and routes returning read data to the owner.
- Sits between the IFU/DMA logic and the ICCM memory instance in the memory wrapper.

Parameters:
ICCM_BITS, 16, ICCM byte-address width; address ports are [ICCM_BITS-1:1].
RD_LAT, 2, cycles from registered iccm_rden to valid iccm_rd_data; legal 1..3.
DMA_STARVE_MAX, 7, consecutive denied DMA cycles before DMA outranks fetch; legal 1..15.

Ports:
clk  in  1  core clock.
rst  in  1  reset; asynchronous, active-high.
corr_req  in  1  ECC correction write-back request.
corr_addr  in  ICCM_BITS-1  correction address.
corr_data  in  78  corrected data with ECC.
corr_gnt  out  1  correction granted this cycle.
fetch_req  in  1  fetch read request.
fetch_tid  in  1  requesting thread.
fetch_addr  in  ICCM_BITS-1  fetch address.
fetch_flush  in  1  kill all in-flight fetch responses.
fetch_gnt  out  1  fetch granted this cycle.
dma_req  in  1  DMA request.
dma_write  in  1  1 = write, 0 = read.
dma_size  in  3  DMA write size.
dma_addr  in  ICCM_BITS-1  DMA address.
dma_wdata  in  78  DMA write data with ECC.
dma_gnt  out  1  DMA granted this cycle.
iccm_wren  out  1  ICCM write strobe (registered).
iccm_rden  out  1  ICCM read strobe (registered).
iccm_rw_addr  out  ICCM_BITS-1  ICCM address (registered).
iccm_wr_size  out  3  ICCM write size (registered).
iccm_wr_data  out  78  ICCM write data (registered).
iccm_rd_data  in  64  ICCM read data.
fetch_rsp_valid  out  1  fetch read data valid.
fetch_rsp_tid  out  1  thread owning fetch_rsp_valid.
dma_rsp_valid  out  1  DMA read data valid.
rsp_data  out  64  pass-through of iccm_rd_data.
busy  out  1  any read in flight or any strobe asserted.

Behaviour:
- Reset: all registered outputs, the starve counter and the in-flight pipeline clear to 0. The rst assertion takes effect asynchronously; in-flight reads are dropped and no response is ever emitted for them.
- Grant, cycle N: combinational from requests; at most one of corr_gnt, fetch_gnt, dma_gnt is high.
- Priority order:
  1. corr_req always wins.
  2. DMA wins if dma_req is high and starve_cnt == DMA_STARVE_MAX.
  3. Otherwise fetch.
  4. Otherwise DMA.
- Strobes, cycle N+1: the granted access appears registered on the iccm_* outputs.
  - Correction: iccm_wren=1, iccm_wr_size=3'b011, data = corr_data.
  - DMA write: iccm_wren=1, size = dma_size, data = dma_wdata.
  - Fetch or DMA read: iccm_rden=1; iccm_wr_data and iccm_wr_size hold 0.
  - With no grant, both strobes are 0. Address holds its last value.
- Read tracking: a shift pipeline RD_LAT deep carries {valid, is_dma, tid}.
  - Response valid appears at N+1+RD_LAT, for exactly one cycle.
  - No back-pressure is applied to responses.
- fetch_flush: clears the valid bit of every fetch entry in the pipeline, plus any fetch grant issued in the same cycle. DMA entries are unaffected.
- Starve counter (4-bit):
  - Increments when dma_req && !dma_gnt.
  - Saturates at DMA_STARVE_MAX.
  - Clears when dma_gnt is high or dma_req is low.
  - A correction still preempts a starved DMA, and the counter holds at MAX.
- Back-to-back grants are allowed every cycle. Writes do not stall reads.
- busy = iccm_wren | iccm_rden | any pipeline valid.

Test Plan:
- Reset release, no requests -> all outputs 0, busy=0 for 10 cycles.
- fetch_req=1, tid=1, addr=0x40 at cycle 5, RD_LAT=2 -> fetch_gnt at cycle 5, iccm_rden at cycle 6 with addr 0x40, fetch_rsp_valid=1 with tid=1 at cycle 8 only.
- corr_req, fetch_req and dma_req all high at cycle 3 -> corr_gnt only. Cycle 4: iccm_wren=1, wr_size=3. Fetch is granted at cycle 4.
- fetch_req held high and DMA read held pending, DMA_STARVE_MAX=7 -> fetch is granted for 7 cycles, dma_gnt on the 8th, counter returns to 0, dma_rsp_valid 3 cycles later.
- Two fetch reads granted in cycles 10 and 11, fetch_flush at cycle 12 -> no fetch_rsp_valid is asserted. A DMA read granted at cycle 11 instead -> dma_rsp_valid at cycle 14.
- rst asserted at cycle 7 with a read granted at cycle 6 -> strobes drop immediately, and no response is asserted after reset is released.
